// File: rtl/life_pkg.sv
// ----------------------------------------------------------------------------
// life_pkg
// Shared definitions for the Life-like cellular automaton row:
//   NBR_W         width of a per-cell neighbour count (0..8)
//   RULE_B3       default birth mask (born with exactly 3 neighbours)
//   RULE_S23      default survive mask (survive with 2 or 3 neighbours)
//   state_t       row sequencer states
//   popcount()    population count over a zero-padded vector
// ----------------------------------------------------------------------------
package life_pkg;

    localparam int         NBR_W    = 4;
    localparam logic [8:0] RULE_B3  = 9'b000001000;
    localparam logic [8:0] RULE_S23 = 9'b000001100;

    // Widest row popcount() accepts; callers zero-pad narrower rows.
    localparam int         POP_MAX  = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    function automatic logic [8:0] popcount(input logic [POP_MAX-1:0] v);
        logic [8:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX; i++) begin
            n = n + {8'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/life_nbr_count.sv
// ----------------------------------------------------------------------------
// life_nbr_count
// Combinational live-neighbour counter for one cell.
// Ports:
//   nbrs   in   8       the eight surrounding cells, one bit each
//   count  out  NBR_W   number of set bits in nbrs (0..8)
// ----------------------------------------------------------------------------
module life_nbr_count
    import life_pkg::*;
(
    input  logic [7:0]       nbrs,
    output logic [NBR_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + {{(NBR_W-1){1'b0}}, nbrs[i]};
        end
    end

endmodule

// File: rtl/life_row.sv
// ----------------------------------------------------------------------------
// life_row
// One row of W Life-like cells with a programmable birth/survive rule. The
// rows above and below arrive as vectors so rows tile into a grid. A step is
// a 3-cycle transaction: accept (snapshot rows) -> count neighbours -> update.
//
// Build option: define LIFE_ROW_WRAP_EN for a toroidal row (column -1 is
// column W-1 and column W is column 0 in all three rows); otherwise columns
// outside the row read as dead.
//
// Ports:
//   clk         in   1            rising-edge clock
//   _rst        in   1            asynchronous active-low reset
//   load_valid  in   1            overwrite cells with load_data (IDLE only)
//   load_data   in   W            pattern to load
//   step_valid  in   1            request one generation
//   step_ready  out  1            step can be accepted this cycle
//   top_row     in   W            row above, sampled on step accept
//   bot_row     in   W            row below, sampled on step accept
//   cells       out  W            current generation
//   gen_count   out  CNT_W        generations since reset/load (saturating)
//   alive_cnt   out  clog2(W+1)   live cells in cells
//   stable      out  1            last step left cells unchanged
//   done        out  1            one-cycle pulse when a step result lands
// ----------------------------------------------------------------------------
module life_row
    import life_pkg::*;
#(
    parameter int           W            = 8,
    parameter logic [W-1:0] INIT         = '0,
    parameter logic [8:0]   BIRTH_MASK   = RULE_B3,
    parameter logic [8:0]   SURVIVE_MASK = RULE_S23,
    parameter int           CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   _rst,
    input  logic                   load_valid,
    input  logic [W-1:0]           load_data,
    input  logic                   step_valid,
    output logic                   step_ready,
    input  logic [W-1:0]           top_row,
    input  logic [W-1:0]           bot_row,
    output logic [W-1:0]           cells,
    output logic [CNT_W-1:0]       gen_count,
    output logic [$clog2(W+1)-1:0] alive_cnt,
    output logic                   stable,
    output logic                   done
);

    localparam int AW = $clog2(W+1);

    // Rule masks padded to 16 entries so a 4-bit count indexes them cleanly.
    localparam logic [15:0] BIRTH_LUT   = {7'd0, BIRTH_MASK};
    localparam logic [15:0] SURVIVE_LUT = {7'd0, SURVIVE_MASK};

    function automatic logic [AW-1:0] pop_row(input logic [W-1:0] v);
        logic [POP_MAX-1:0] wide;
        wide        = '0;
        wide[W-1:0] = v;
        return AW'(popcount(wide));
    endfunction

    state_t           state;
    logic             step_accept;
    logic [W-1:0]     top_q;
    logic [W-1:0]     bot_q;
    logic [W+1:0]     top_x;
    logic [W+1:0]     bot_x;
    logic [W+1:0]     cell_x;
    logic [NBR_W-1:0] nbr_now [W];
    logic [NBR_W-1:0] nbr_q   [W];
    logic [W-1:0]     next_cells;

    // Load has priority over step, so a pending load hides readiness.
    assign step_ready  = (state == ST_IDLE) && !load_valid;
    assign step_accept = step_ready && step_valid;

    // Rows padded by one column each side: bit 0 is column -1, bit W+1 is
    // column W. cells needs no snapshot: nothing can change it until UPDATE.
`ifdef LIFE_ROW_WRAP_EN
    assign top_x  = {top_q[0], top_q, top_q[W-1]};
    assign bot_x  = {bot_q[0], bot_q, bot_q[W-1]};
    assign cell_x = {cells[0], cells, cells[W-1]};
`else
    assign top_x  = {1'b0, top_q, 1'b0};
    assign bot_x  = {1'b0, bot_q, 1'b0};
    assign cell_x = {1'b0, cells, 1'b0};
`endif

    for (genvar c = 0; c < W; c++) begin : g_col
        life_nbr_count u_nbr (
            .nbrs  ({top_x[c+2:c], bot_x[c+2:c], cell_x[c+2], cell_x[c]}),
            .count (nbr_now[c])
        );
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        next_cells = cells;
        for (int c = 0; c < W; c++) begin
            next_cells[c] = cells[c] ? SURVIVE_LUT[nbr_q[c]] : BIRTH_LUT[nbr_q[c]];
        end
    end

    // NOTE: datapath snapshots carry no reset; they are only consumed in the
    // state that follows their capture, so their power-up value never matters.
    always_ff @(posedge clk) begin
        if (step_accept) begin
            top_q <= top_row;
            bot_q <= bot_row;
        end
        if (state == ST_COUNT) begin
            nbr_q <= nbr_now;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state     <= ST_IDLE;
            cells     <= INIT;
            gen_count <= '0;
            alive_cnt <= pop_row(INIT);
            stable    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_valid) begin
                        cells     <= load_data;
                        gen_count <= '0;
                        stable    <= 1'b0;
                        alive_cnt <= pop_row(load_data);
                    end else if (step_valid) begin
                        state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    cells     <= next_cells;
                    stable    <= (next_cells == cells);
                    alive_cnt <= pop_row(next_cells);
                    if (gen_count != '1) begin
                        gen_count <= gen_count + CNT_W'(1);
                    end
                    done      <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_row.sv
// ----------------------------------------------------------------------------
// tb_life_row
// Directed bench for life_row. Two instances share clock and reset:
//   dut5  W=5, INIT=5'b10001          blinker, still life, load rules, busy,
//                                     mid-step reset, model-checked vectors
//   dut4  W=4, CNT_W=2                edge/wrap behaviour, counter saturation
// Honours LIFE_ROW_WRAP_EN for the expected edge behaviour.
// ----------------------------------------------------------------------------
module tb_life_row;

    logic clk = 1'b0;
    logic _rst;
    always #5 clk = ~clk;

    // dut5 signals
    logic        l5_valid, s5_valid, s5_ready, st5, d5;
    logic [4:0]  l5_data, t5, b5, c5;
    logic [15:0] g5;
    logic [2:0]  a5;

    // dut4 signals
    logic        l4_valid, s4_valid, s4_ready, st4, d4;
    logic [3:0]  l4_data, t4, b4, c4;
    logic [1:0]  g4;
    logic [2:0]  a4;

    int n_total = 0;
    int n_bad   = 0;

    life_row #(.W(5), .INIT(5'b10001)) dut5 (
        .clk(clk), ._rst(_rst),
        .load_valid(l5_valid), .load_data(l5_data),
        .step_valid(s5_valid), .step_ready(s5_ready),
        .top_row(t5), .bot_row(b5),
        .cells(c5), .gen_count(g5), .alive_cnt(a5),
        .stable(st5), .done(d5)
    );

    life_row #(.W(4), .CNT_W(2)) dut4 (
        .clk(clk), ._rst(_rst),
        .load_valid(l4_valid), .load_data(l4_data),
        .step_valid(s4_valid), .step_ready(s4_ready),
        .top_row(t4), .bot_row(b4),
        .cells(c4), .gen_count(g4), .alive_cnt(a4),
        .stable(st4), .done(d4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: counts neighbours column by column.
    function automatic logic [4:0] model5(input logic [4:0] c, input logic [4:0] t,
                                          input logic [4:0] b);
        logic [4:0] r;
        int n, j;
        bit in_row;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            for (int d = -1; d <= 1; d++) begin
                j = i + d;
                in_row = 1'b1;
`ifdef LIFE_ROW_WRAP_EN
                if (j < 0) j = 4;
                if (j > 4) j = 0;
`else
                if (j < 0 || j > 4) in_row = 1'b0;
`endif
                if (in_row) begin
                    n += int'(t[j]) + int'(b[j]);
                    if (d != 0) n += int'(c[j]);
                end
            end
            r[i] = c[i] ? (n == 2 || n == 3) : (n == 3);
        end
        return r;
    endfunction

    task automatic load5(input logic [4:0] data);
        l5_valid = 1'b1;
        l5_data  = data;
        tick();
        l5_valid = 1'b0;
    endtask

    // One full step on dut5; rows are scrambled and a load is attempted
    // while busy, both of which must have no effect on the result.
    task automatic step5(input logic [4:0] top, input logic [4:0] bot, input string tag);
        t5 = top;
        b5 = bot;
        s5_valid = 1'b1;
        #1;
        check({tag, "_ready"}, s5_ready, 1);
        tick();
        s5_valid = 1'b0;
        t5 = ~top;
        b5 = ~bot;
        l5_valid = 1'b1;
        l5_data  = 5'b11011;
        #1;
        check({tag, "_busy_count"}, s5_ready, 0);
        check({tag, "_nodone_count"}, d5, 0);
        tick();
        check({tag, "_busy_update"}, s5_ready, 0);
        check({tag, "_nodone_update"}, d5, 0);
        tick();
        l5_valid = 1'b0;
        check({tag, "_done"}, d5, 1);
        tick();
        check({tag, "_done_end"}, d5, 0);
    endtask

    task automatic step4(input logic [3:0] top, input logic [3:0] bot, input string tag);
        t4 = top;
        b4 = bot;
        s4_valid = 1'b1;
        #1;
        check({tag, "_ready"}, s4_ready, 1);
        tick();
        s4_valid = 1'b0;
        t4 = '0;
        b4 = '0;
        tick();
        check({tag, "_busy"}, s4_ready, 0);
        tick();
        check({tag, "_done"}, d4, 1);
        tick();
        check({tag, "_done_end"}, d4, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] exp5;
        logic [3:0] exp4;
        logic [2:0] exp4_alive;

        _rst = 1'b1;
        l5_valid = 1'b0; l5_data = '0; s5_valid = 1'b0; t5 = '0; b5 = '0;
        l4_valid = 1'b0; l4_data = '0; s4_valid = 1'b0; t4 = '0; b4 = '0;
        #2 _rst = 1'b0;
        #1;

        // Reset state
        check("rst_cells5", c5, 5'b10001);
        check("rst_alive5", a5, 2);
        check("rst_gen5", g5, 0);
        check("rst_stable5", st5, 0);
        check("rst_done5", d5, 0);
        check("rst_ready5", s5_ready, 1);
        check("rst_cells4", c4, 0);
        check("rst_alive4", a4, 0);
        tick();
        tick();
        _rst = 1'b1;

        // Load priority over step in the same cycle
        l5_valid = 1'b1;
        l5_data  = 5'b00100;
        s5_valid = 1'b1;
        #1;
        check("ldpri_ready", s5_ready, 0);
        tick();
        l5_valid = 1'b0;
        s5_valid = 1'b0;
        check("ldpri_cells", c5, 5'b00100);
        check("ldpri_gen", g5, 0);
        check("ldpri_alive", a5, 1);
        check("ldpri_stable", st5, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ldpri_nodone", d5, 0);
        end
        check("ldpri_hold", c5, 5'b00100);

        // Row-only blinker
        step5(5'b00100, 5'b00100, "blink1");
        check("blink1_cells", c5, 5'b01110);
        check("blink1_gen", g5, 1);
        check("blink1_alive", a5, 3);
        check("blink1_stable", st5, 0);
        step5(5'b00100, 5'b00100, "blink2");
        check("blink2_cells", c5, 5'b01010);
        check("blink2_gen", g5, 2);
        check("blink2_alive", a5, 2);

        // Still life: two neighbours is not a birth
        load5(5'b00000);
        step5(5'b00110, 5'b00110, "still");
        check("still_cells", c5, 0);
        check("still_stable", st5, 1);
        check("still_alive", a5, 0);
        check("still_gen", g5, 1);

        // Golden-model vectors
        load5(5'b10110);
        exp5 = model5(5'b10110, 5'b01011, 5'b11001);
        step5(5'b01011, 5'b11001, "model1");
        check("model1_cells", c5, exp5);
        exp5 = model5(c5, 5'b10101, 5'b00000);
        step5(5'b10101, 5'b00000, "model2");
        check("model2_cells", c5, exp5);

        // Busy: step_valid held, accepts every third cycle
        load5(5'b00100);
        t5 = 5'b00100;
        b5 = 5'b00100;
        s5_valid = 1'b1;
        tick();
        check("busy_t0_ready", s5_ready, 0);
        tick();
        check("busy_t1_ready", s5_ready, 0);
        check("busy_t1_done", d5, 0);
        tick();
        check("busy_t2_done", d5, 1);
        check("busy_t2_cells", c5, 5'b01110);
        check("busy_t2_ready", s5_ready, 1);
        tick();
        check("busy_t3_ready", s5_ready, 0);
        check("busy_t3_done", d5, 0);
        tick();
        tick();
        check("busy_t5_done", d5, 1);
        check("busy_t5_cells", c5, 5'b01010);
        tick();
        s5_valid = 1'b0;
        check("busy_t6_ready", s5_ready, 0);
        tick();
        tick();
        check("busy_t8_done", d5, 1);
        check("busy_t8_cells", c5, 5'b01010);
        check("busy_t8_stable", st5, 1);
        check("busy_t8_gen", g5, 3);
        tick();

        // Reset during COUNT
        t5 = 5'b11111;
        b5 = 5'b11111;
        s5_valid = 1'b1;
        tick();
        s5_valid = 1'b0;
        _rst = 1'b0;
        #1;
        check("midrst_cells", c5, 5'b10001);
        check("midrst_gen", g5, 0);
        check("midrst_alive", a5, 2);
        check("midrst_done", d5, 0);
        tick();
        check("midrst_done_a", d5, 0);
        _rst = 1'b1;
        tick();
        check("midrst_done_b", d5, 0);
        tick();
        check("midrst_done_c", d5, 0);
        check("midrst_hold", c5, 5'b10001);
        check("midrst_ready", s5_ready, 1);

        // Row edges on W=4
`ifdef LIFE_ROW_WRAP_EN
        exp4 = 4'b1011;
        exp4_alive = 3'd3;
`else
        exp4 = 4'b0011;
        exp4_alive = 3'd2;
`endif
        l4_valid = 1'b1;
        l4_data  = 4'b1001;
        tick();
        l4_valid = 1'b0;
        check("wrap_load", c4, 4'b1001);
        step4(4'b0001, 4'b0001, "wrap");
        check("wrap_cells", c4, exp4);
        check("wrap_alive", a4, exp4_alive);
        check("wrap_gen", g4, 1);

        // Generation counter saturation (CNT_W=2)
        step4(4'b0000, 4'b0000, "sat2");
        check("sat2_gen", g4, 2);
        step4(4'b0000, 4'b0000, "sat3");
        check("sat3_gen", g4, 3);
        step4(4'b0000, 4'b0000, "sat4");
        check("sat4_gen", g4, 3);
        step4(4'b0000, 4'b0000, "sat5");
        check("sat5_gen", g4, 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
